ber_counter: RTL
================

// Module: ber_counter
// PURPOSE
//  Consumes the three phase flags of the BER control stage and the ref/rx bit streams.
//  SYNC phase: sweeps 511 candidate delays of the local PRBS9 reference against the
//  received bits, 511 symbols per delay, and keeps the delay with the fewest errors.
//  COUNT phase: accumulates errors and total bits at that delay.
//  Sits after the slicer, downstream of the BER control stage, at symbol rate (i_ctrl).
// PARAMETERS
//  PRBS_LEN   511  taps in reference delay line = number of candidate delays
//  CNT_BITS   64   width of o_err_count / o_bit_count
// PORTS
//  clk                        in   1         system clock
//  i_reset_n                  in   1         async active-low reset
//  i_ctrl                     in   1         symbol-rate enable (1 clk per symbol)
//  i_start_synchro            in   1         level: SYNC phase active
//  i_prbs_cmp_curr_addr_done  in   1         level: last symbol of current delay
//  i_start_ber_counter        in   1         level: COUNT phase active
//  i_ref_bit                  in   1         local PRBS9 reference bit
//  i_rx_bit                   in   1         sliced received bit
//  o_sync_done                out  1         best delay latched, COUNT running
//  o_best_addr                out  9         chosen delay, 0..510
//  o_min_errors               out  10        errors at o_best_addr over 511 symbols
//  o_err_count                out  CNT_BITS  bit errors in COUNT phase
//  o_bit_count                out  CNT_BITS  bits compared in COUNT phase
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; every output 0 except o_min_errors=1023;
//    delay line, addr, acc = 0.
//  - Nothing updates when i_ctrl=0. All events are qualified by i_ctrl=1.
//  - Delay line: on i_ctrl, ref_buf[509:0] <= {ref_buf[508:0], i_ref_bit}.
//    Tap k of {ref_buf, i_ref_bit}: k=0 is current i_ref_bit, k=d is the ref bit d symbols ago.
//    err = i_rx_bit ^ tap[addr]. Compare uses the pre-shift buffer.
//  - FSM IDLE -> SYNC: i_start_synchro=1 and i_ctrl=1. This symbol is processed.
//  - FSM SYNC -> COUNT: i_start_ber_counter=1 and i_ctrl=1. This symbol is counted.
//    o_sync_done goes 1 on the following clk. COUNT is held until reset.
//  - SYNC, each i_ctrl: acc(9b) += err.
//  - SYNC, i_ctrl and i_prbs_cmp_curr_addr_done: tot = acc+err (10b).
//    If tot < o_min_errors (strict, so ties keep the earlier addr):
//    o_min_errors <= tot, o_best_addr <= addr.
//    Then acc <= 0 and addr <= (addr==510) ? 0 : addr+1.
//  - SYNC: o_best_addr / o_min_errors change only at done events.
//  - COUNT, each i_ctrl: err uses tap[o_best_addr]; o_bit_count += 1; o_err_count += err.
//  - i_prbs_cmp_curr_addr_done outside SYNC is ignored.
//  - i_start_ber_counter seen in IDLE: go directly to COUNT with o_best_addr=0, o_min_errors=1023.
//  - Counter overflow: see CONFIGURATION.
//  - i_reset_n low at any time, including mid-SYNC: full clear, back to IDLE.
//  - Latency: counters and best-delay results update 1 clk after the qualifying i_ctrl edge.
// CONFIGURATION
//  BER_CNT_SAT_EN defined: o_err_count and o_bit_count saturate at all-ones.
//    Both freeze once o_bit_count saturates, so the ratio stays consistent.
//  BER_CNT_SAT_EN undefined: both counters wrap modulo 2^CNT_BITS independently.
// TESTING
//  1 rx = ref delayed 37 symbols, full SYNC+COUNT
//    -> o_best_addr=37, o_min_errors=0, o_err_count=0, o_bit_count=#COUNT symbols.
//  2 delay 0, rx inverted every 100th symbol
//    -> o_best_addr=0, o_min_errors=5, err/bit ratio 1/100 in COUNT.
//  3 delay 510 -> o_best_addr=510; addr wraps 510->0 after the 511th done pulse.
//  4 i_ctrl=1 one clk in 4; flags held across gaps -> identical results to i_ctrl=1 every clk.
//  5 i_reset_n pulsed low mid-SYNC (addr~200) -> all outputs at reset values, FSM IDLE.
//    Rerun gives the correct addr.
//  6 CNT_BITS=4, 20 COUNT symbols, rx=~ref
//    -> with BER_CNT_SAT_EN: both counters = 15. Without: both = 4.

Source files
------------

// File: rtl/ber_counter.sv
// BER counter: sweeps PRBS reference delays to find the best alignment, then counts errors/bits.
// Optional macro BER_CNT_SAT_EN makes the error/bit counters saturate instead of wrapping.
module ber_counter #(
  parameter int PRBS_LEN = 511,
  parameter int CNT_BITS = 64
) (
  input  logic                clk,
  input  logic                i_reset_n,
  input  logic                i_ctrl,
  input  logic                i_start_synchro,
  input  logic                i_prbs_cmp_curr_addr_done,
  input  logic                i_start_ber_counter,
  input  logic                i_ref_bit,
  input  logic                i_rx_bit,
  output logic                o_sync_done,
  output logic [8:0]          o_best_addr,
  output logic [9:0]          o_min_errors,
  output logic [CNT_BITS-1:0] o_err_count,
  output logic [CNT_BITS-1:0] o_bit_count
);

  typedef enum logic [1:0] {IDLE, SYNC, COUNT} state_t;

  localparam logic [8:0] LAST = 9'(PRBS_LEN - 1);

  state_t                state;
  logic [PRBS_LEN-2:0]   ref_buf;
  logic [PRBS_LEN-1:0]   taps;
  logic [8:0]            addr;
  logic [8:0]            acc;
  logic [8:0]            sel;
  logic                  err;
  logic                  do_sync;
  logic                  do_count;
  logic [9:0]            tot;
  logic [CNT_BITS-1:0]   bit_nxt;
  logic [CNT_BITS-1:0]   err_nxt;

  // tap k is the reference bit k symbols ago; tap 0 is the live input
  assign taps = {ref_buf, i_ref_bit};

  always_comb begin
    do_count = i_ctrl && (state == COUNT || i_start_ber_counter);
    do_sync  = i_ctrl && !i_start_ber_counter &&
               (state == SYNC || (state == IDLE && i_start_synchro));
    sel      = do_count ? o_best_addr : addr;
    err      = i_rx_bit ^ taps[sel];
    tot      = {1'b0, acc} + 10'(err);
    bit_nxt  = o_bit_count + CNT_BITS'(1);
    err_nxt  = o_err_count + CNT_BITS'(err);
`ifdef BER_CNT_SAT_EN
    // err_count never exceeds bit_count, so freezing both on bit saturation keeps the ratio
    if (&o_bit_count) begin
      bit_nxt = o_bit_count;
      err_nxt = o_err_count;
    end
`endif
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      ref_buf      <= '0;
      addr         <= '0;
      acc          <= '0;
      o_sync_done  <= 1'b0;
      o_best_addr  <= '0;
      o_min_errors <= 10'd1023;
      o_err_count  <= '0;
      o_bit_count  <= '0;
    end else if (i_ctrl) begin
      ref_buf <= {ref_buf[PRBS_LEN-3:0], i_ref_bit};
      if (do_count) begin
        state       <= COUNT;
        o_sync_done <= 1'b1;
        o_bit_count <= bit_nxt;
        o_err_count <= err_nxt;
      end
      if (do_sync) begin
        state <= SYNC;
        if (i_prbs_cmp_curr_addr_done) begin
          if (tot < o_min_errors) begin
            o_min_errors <= tot;
            o_best_addr  <= addr;
          end
          acc  <= '0;
          addr <= (addr == LAST) ? 9'd0 : addr + 9'd1;
        end else begin
          acc <= acc + 9'(err);
        end
      end
    end
  end

endmodule
